// File: rtl/bank_tracker_pkg.sv
// ---------------------------------------------------------------------------
// bank_tracker_pkg
// Shared defaults for the DRAM open-row tracker and the helper that sizes
// the bank-index fields.
// ---------------------------------------------------------------------------
package bank_tracker_pkg;

   localparam int DEF_NBANKS      = 4;
   localparam int DEF_ROW_W       = 11;
   localparam int DEF_IDLE_W      = 8;
   localparam int DEF_IDLE_CYCLES = 64;

   // Width of a bank index. It is never below one bit, so a_bank and
   // close_bank stay legal vectors for every supported bank count.
   function automatic int bank_w(input int nbanks);
      return (nbanks <= 2) ? 1 : $clog2(nbanks);
   endfunction

endpackage : bank_tracker_pkg

// File: rtl/bank_entry.sv
// ---------------------------------------------------------------------------
// bank_entry
// State for a single DRAM bank: open row address, open flag and a
// saturating idle counter. The entry flags itself as expired when it has
// been open and untouched for IDLE_CYCLES cycles.
//
// Ports
//   sys_clk  : clock, rising edge
//   resl     : asynchronous active-low reset
//   load     : activate this bank with row_in (wins over every close source)
//   close    : any close event for this bank (ack, precharge, precharge_all)
//   hit      : qualified row hit on this bank this cycle
//   row_in   : row address to load
//   row      : registered open row
//   is_open  : registered open flag
//   expired  : open and idle counter at IDLE_CYCLES (never when IDLE_CYCLES=0)
// ---------------------------------------------------------------------------
module bank_entry
   import bank_tracker_pkg::*;
#(
   parameter int ROW_W       = DEF_ROW_W,
   parameter int IDLE_W      = DEF_IDLE_W,
   parameter int IDLE_CYCLES = DEF_IDLE_CYCLES
) (
   input  logic             sys_clk,
   input  logic             resl,
   input  logic             load,
   input  logic             close,
   input  logic             hit,
   input  logic [ROW_W-1:0] row_in,
   output logic [ROW_W-1:0] row,
   output logic             is_open,
   output logic             expired
);

   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);

   logic [IDLE_W-1:0] idle_cnt;

   always_ff @(posedge sys_clk or negedge resl) begin
      if (!resl) begin
         row      <= '0;
         is_open  <= 1'b0;
         idle_cnt <= '0;
      end else if (load) begin
         row      <= row_in;
         is_open  <= 1'b1;
         idle_cnt <= '0;
      end else if (close) begin
         is_open  <= 1'b0;
         idle_cnt <= '0;
      end else if (is_open) begin
         // A hit restarts the idle window; otherwise count up and stick at
         // the limit. With IDLE_CYCLES=0 the limit is 0, so it never moves.
         if (hit) begin
            idle_cnt <= '0;
         end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
         end
      end
   end

   assign expired = (IDLE_CYCLES != 0) && is_open && (idle_cnt == IDLE_MAX);

endmodule : bank_entry

// File: rtl/bank_tracker.sv
// ---------------------------------------------------------------------------
// bank_tracker
// Tracks the open row of each DRAM bank, classifies the current access as
// hit / open-row miss / closed-bank miss with zero latency, and asks the
// controller to close banks that have sat idle for IDLE_CYCLES cycles.
//
// Handshake: close_req/close_bank describe the lowest-index expired bank.
// The controller precharges it and raises close_ack for one cycle; the
// entry named by close_bank closes on that edge. close_ack while close_req
// is low does nothing. There is no backpressure on the request side: the
// request stays up until acknowledged or until a hit/activate/precharge on
// that bank clears it.
//
// Ports
//   sys_clk, resl            : clock and asynchronous active-low reset
//   a_bank, a_row            : bank and row of the current access
//   lookup                   : qualifies match/miss_open/miss_closed
//   newrow                   : activate a_row in a_bank
//   precharge                : close a_bank
//   precharge_all            : close every bank (a concurrent newrow wins)
//   close_ack                : controller has precharged close_bank
//   match/miss_open/miss_closed : access classification (one-hot on lookup)
//   close_req, close_bank    : idle-close request and its bank
//   open_mask                : per-bank open flags
// ---------------------------------------------------------------------------
module bank_tracker
   import bank_tracker_pkg::*;
#(
   parameter  int NBANKS      = DEF_NBANKS,
   parameter  int ROW_W       = DEF_ROW_W,
   parameter  int IDLE_W      = DEF_IDLE_W,
   parameter  int IDLE_CYCLES = DEF_IDLE_CYCLES,
   localparam int BANK_W      = bank_w(NBANKS)
) (
   input  logic              sys_clk,
   input  logic              resl,
   input  logic [BANK_W-1:0] a_bank,
   input  logic [ROW_W-1:0]  a_row,
   input  logic              lookup,
   input  logic              newrow,
   input  logic              precharge,
   input  logic              precharge_all,
   input  logic              close_ack,
   output logic              match,
   output logic              miss_open,
   output logic              miss_closed,
   output logic              close_req,
   output logic [BANK_W-1:0] close_bank,
   output logic [NBANKS-1:0] open_mask
);

   logic [ROW_W-1:0]  rows [NBANKS];
   logic [NBANKS-1:0] expired;
   logic [NBANKS-1:0] load_vec;
   logic [NBANKS-1:0] close_vec;
   logic [NBANKS-1:0] hit_vec;

   logic              sel_open;
   logic              row_eq;

   // Classification of the addressed entry.
   assign sel_open    = open_mask[a_bank];
   assign row_eq      = (rows[a_bank] == a_row);
   assign match       = lookup &&  sel_open &&  row_eq;
   assign miss_open   = lookup &&  sel_open && !row_eq;
   assign miss_closed = lookup && !sel_open;

   // Lowest-index expired bank wins; scanning downward lets the lowest
   // index overwrite any higher one.
   always_comb begin
      close_bank = '0;
      for (int i = NBANKS - 1; i >= 0; i--) begin
         if (expired[i]) begin
            close_bank = BANK_W'(i);
         end
      end
   end

   assign close_req = |expired;

   // Per-bank control. load has priority inside the entry, so newrow beats
   // any close source targeting the same bank in the same cycle.
   always_comb begin
      load_vec  = '0;
      close_vec = '0;
      hit_vec   = '0;
      for (int i = 0; i < NBANKS; i++) begin
         load_vec[i]  = newrow && (a_bank == BANK_W'(i));
         close_vec[i] = (close_req && close_ack && (close_bank == BANK_W'(i)))
                     || (precharge && (a_bank == BANK_W'(i)))
                     || precharge_all;
         hit_vec[i]   = match && (a_bank == BANK_W'(i));
      end
   end

   for (genvar g = 0; g < NBANKS; g++) begin : g_entry
      bank_entry #(
         .ROW_W       (ROW_W),
         .IDLE_W      (IDLE_W),
         .IDLE_CYCLES (IDLE_CYCLES)
      ) u_entry (
         .sys_clk (sys_clk),
         .resl    (resl),
         .load    (load_vec[g]),
         .close   (close_vec[g]),
         .hit     (hit_vec[g]),
         .row_in  (a_row),
         .row     (rows[g]),
         .is_open (open_mask[g]),
         .expired (expired[g])
      );
   end

endmodule : bank_tracker

// File: tb/tb_bank_tracker.sv
// ---------------------------------------------------------------------------
// tb_bank_tracker
// Directed self-checking bench for bank_tracker with NBANKS=4, ROW_W=11,
// IDLE_CYCLES=8. Inputs change 1 time unit after a rising edge; outputs
// are checked 1 time unit after inputs settle, well away from the edge.
// ---------------------------------------------------------------------------
module tb_bank_tracker;

   localparam int NBANKS      = 4;
   localparam int ROW_W       = 11;
   localparam int IDLE_W      = 8;
   localparam int IDLE_CYCLES = 8;
   localparam int BANK_W      = 2;

   logic              sys_clk;
   logic              resl;
   logic [BANK_W-1:0] a_bank;
   logic [ROW_W-1:0]  a_row;
   logic              lookup;
   logic              newrow;
   logic              precharge;
   logic              precharge_all;
   logic              close_ack;
   logic              match;
   logic              miss_open;
   logic              miss_closed;
   logic              close_req;
   logic [BANK_W-1:0] close_bank;
   logic [NBANKS-1:0] open_mask;

   int checks   = 0;
   int failures = 0;

   bank_tracker #(
      .NBANKS      (NBANKS),
      .ROW_W       (ROW_W),
      .IDLE_W      (IDLE_W),
      .IDLE_CYCLES (IDLE_CYCLES)
   ) dut (
      .sys_clk       (sys_clk),
      .resl          (resl),
      .a_bank        (a_bank),
      .a_row         (a_row),
      .lookup        (lookup),
      .newrow        (newrow),
      .precharge     (precharge),
      .precharge_all (precharge_all),
      .close_ack     (close_ack),
      .match         (match),
      .miss_open     (miss_open),
      .miss_closed   (miss_closed),
      .close_req     (close_req),
      .close_bank    (close_bank),
      .open_mask     (open_mask)
   );

   // ---------------- clock / reset ----------------
   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic idle_inputs();
      lookup        = 1'b0;
      newrow        = 1'b0;
      precharge     = 1'b0;
      precharge_all = 1'b0;
      close_ack     = 1'b0;
      a_bank        = '0;
      a_row         = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      resl = 1'b0;
      step();
      step();
      resl = 1'b1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic activate(input logic [BANK_W-1:0] b, input logic [ROW_W-1:0] r);
      a_bank = b; a_row = r; newrow = 1'b1;
      step();
      newrow = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (open_mask !== 4'b0000) begin $display("FAIL reset_mask got=%b exp=0000", open_mask); failures++; end
      checks++; if ({close_req, close_bank} !== 3'b000) begin $display("FAIL reset_close got=%b exp=000", {close_req, close_bank}); failures++; end
      checks++; if ({match, miss_open, miss_closed} !== 3'b000) begin $display("FAIL reset_class_nolookup got=%b exp=000", {match, miss_open, miss_closed}); failures++; end
   endtask

   task automatic test_hit();
      do_reset();
      lookup = 1'b1; a_bank = 2'd2; a_row = 11'h123;
      #1;
      checks++; if ({match, miss_open, miss_closed} !== 3'b001) begin $display("FAIL hit_cold_miss got=%b exp=001", {match, miss_open, miss_closed}); failures++; end
      lookup = 1'b0;
      activate(2'd2, 11'h123);
      lookup = 1'b1;
      #1;
      checks++; if ({match, miss_open, miss_closed} !== 3'b100) begin $display("FAIL hit_match got=%b exp=100", {match, miss_open, miss_closed}); failures++; end
      checks++; if (open_mask !== 4'b0100) begin $display("FAIL hit_mask got=%b exp=0100", open_mask); failures++; end
      lookup = 1'b0;
   endtask

   task automatic test_miss_precharge();
      // continues from test_hit: bank 2 holds row 0x123
      lookup = 1'b1; a_bank = 2'd2; a_row = 11'h124;
      #1;
      checks++; if ({match, miss_open, miss_closed} !== 3'b010) begin $display("FAIL miss_open got=%b exp=010", {match, miss_open, miss_closed}); failures++; end
      lookup = 1'b0; precharge = 1'b1;
      step();
      precharge = 1'b0; lookup = 1'b1; a_row = 11'h123;
      #1;
      checks++; if ({match, miss_open, miss_closed} !== 3'b001) begin $display("FAIL after_precharge got=%b exp=001", {match, miss_open, miss_closed}); failures++; end
      checks++; if (open_mask !== 4'b0000) begin $display("FAIL precharge_mask got=%b exp=0000", open_mask); failures++; end
      lookup = 1'b0;
   endtask

   task automatic test_expiry();
      do_reset();
      activate(2'd1, 11'h005);   // bank1 counter 0
      activate(2'd3, 11'h006);   // bank1 1, bank3 0
      repeat (6) step();         // bank1 7, bank3 6
      checks++; if (close_req !== 1'b0) begin $display("FAIL expiry_early got=%b exp=0", close_req); failures++; end
      step();                    // bank1 8, bank3 7
      checks++; if ({close_req, close_bank} !== 3'b101) begin $display("FAIL expiry_first got=%b exp=101", {close_req, close_bank}); failures++; end
      close_ack = 1'b1;
      step();                    // bank1 closed, bank3 8
      close_ack = 1'b0;
      #1;
      checks++; if ({close_req, close_bank} !== 3'b111) begin $display("FAIL expiry_second got=%b exp=111", {close_req, close_bank}); failures++; end
      checks++; if (open_mask !== 4'b1000) begin $display("FAIL expiry_mask1 got=%b exp=1000", open_mask); failures++; end
      close_ack = 1'b1;
      step();
      close_ack = 1'b0;
      #1;
      checks++; if ({close_req, close_bank} !== 3'b000) begin $display("FAIL expiry_done got=%b exp=000", {close_req, close_bank}); failures++; end
      checks++; if (open_mask !== 4'b0000) begin $display("FAIL expiry_mask2 got=%b exp=0000", open_mask); failures++; end
   endtask

   task automatic test_match_refresh();
      do_reset();
      activate(2'd1, 11'h0AA);   // counter 0
      repeat (7) step();         // counter 7
      lookup = 1'b1; a_bank = 2'd1; a_row = 11'h0AA;
      #1;
      checks++; if (match !== 1'b1) begin $display("FAIL refresh_match got=%b exp=1", match); failures++; end
      step();                    // counter cleared
      lookup = 1'b0;
      repeat (7) step();         // counter 7
      checks++; if (close_req !== 1'b0) begin $display("FAIL refresh_no_req got=%b exp=0", close_req); failures++; end
      step();                    // counter 8 -> expired
      checks++; if ({close_req, close_bank} !== 3'b101) begin $display("FAIL refresh_req got=%b exp=101", {close_req, close_bank}); failures++; end
      // hit on the expired bank withdraws the request on the next edge
      lookup = 1'b1;
      step();
      lookup = 1'b0;
      #1;
      checks++; if (close_req !== 1'b0) begin $display("FAIL withdraw_req got=%b exp=0", close_req); failures++; end
      checks++; if (open_mask !== 4'b0010) begin $display("FAIL withdraw_mask got=%b exp=0010", open_mask); failures++; end
   endtask

   task automatic test_ack_ignored();
      do_reset();
      activate(2'd0, 11'h011);
      close_ack = 1'b1;
      step();
      close_ack = 1'b0;
      #1;
      checks++; if (open_mask !== 4'b0001) begin $display("FAIL ack_ignored got=%b exp=0001", open_mask); failures++; end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < NBANKS; i++) activate(BANK_W'(i), ROW_W'(16 + i));
      checks++; if (open_mask !== 4'b1111) begin $display("FAIL b2b_all_open got=%b exp=1111", open_mask); failures++; end
      // newrow and precharge on the same bank: bank stays open with new row
      a_bank = 2'd2; a_row = 11'h055; newrow = 1'b1; precharge = 1'b1;
      step();
      newrow = 1'b0; precharge = 1'b0; lookup = 1'b1;
      #1;
      checks++; if ({match, miss_open, miss_closed} !== 3'b100) begin $display("FAIL b2b_newrow_precharge got=%b exp=100", {match, miss_open, miss_closed}); failures++; end
      lookup = 1'b0;
      a_bank = 2'd0; a_row = 11'h7FF; newrow = 1'b1; precharge_all = 1'b1;
      step();
      newrow = 1'b0; precharge_all = 1'b0;
      #1;
      checks++; if (open_mask !== 4'b0001) begin $display("FAIL b2b_pall_mask got=%b exp=0001", open_mask); failures++; end
      lookup = 1'b1;
      #1;
      checks++; if ({match, miss_open, miss_closed} !== 3'b100) begin $display("FAIL b2b_pall_match got=%b exp=100", {match, miss_open, miss_closed}); failures++; end
      lookup = 1'b0;
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < NBANKS; i++) activate(BANK_W'(i), ROW_W'(32 + i));
      repeat (8) step();          // bank0 reaches 8 first
      checks++; if ({close_req, close_bank} !== 3'b100) begin $display("FAIL areset_pre_req got=%b exp=100", {close_req, close_bank}); failures++; end
      #2;                          // mid-cycle, away from any edge
      lookup = 1'b1; a_bank = 2'd2; a_row = 11'd34;
      resl = 1'b0;
      #1;
      checks++; if (open_mask !== 4'b0000) begin $display("FAIL areset_mask got=%b exp=0000", open_mask); failures++; end
      checks++; if (close_req !== 1'b0) begin $display("FAIL areset_req got=%b exp=0", close_req); failures++; end
      checks++; if ({match, miss_open, miss_closed} !== 3'b001) begin $display("FAIL areset_class got=%b exp=001", {match, miss_open, miss_closed}); failures++; end
      step();
      resl = 1'b1;
      lookup = 1'b0;
      step();
      lookup = 1'b1; a_row = 11'd0;
      #1;
      checks++; if ({match, miss_open, miss_closed} !== 3'b001) begin $display("FAIL areset_after got=%b exp=001", {match, miss_open, miss_closed}); failures++; end
      lookup = 1'b0;
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      resl = 1'b0;
      idle_inputs();
      test_reset();
      test_hit();
      test_miss_precharge();
      test_expiry();
      test_match_refresh();
      test_ack_ignored();
      test_back_to_back();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Safety net so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule : tb_bank_tracker

// File: doc/bank_tracker.md
BANK_TRACKER -- requirements
Module: bank_tracker

Interface
REQ-001 SHALL have parameter NBANKS, default 4, number of tracked DRAM banks (power of 2, 2..16).
REQ-002 SHALL have parameter ROW_W, default 11, row-address width.
REQ-003 SHALL have parameter IDLE_W, default 8, idle-counter width.
REQ-004 SHALL have parameter IDLE_CYCLES, default 64, idle cycles before auto-close request; 0 disables auto-close.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: sys_clk, input, 1, single clock, all state updates on rising edge.
REQ-006 resl, input, 1, asynchronous active-low reset.
REQ-007 a_bank, input, log2(NBANKS), bank select of current access.
REQ-008 a_row, input, ROW_W, row address of current access.
REQ-009 lookup, input, 1, access qualifier; classification outputs meaningful only when high.
REQ-010 newrow, input, 1, activate: load a_row into entry a_bank and mark it open.
REQ-011 precharge, input, 1, close entry a_bank.
REQ-012 precharge_all, input, 1, close all entries.
REQ-013 close_ack, input, 1, controller has precharged close_bank.
REQ-014 match, output, 1, hit: lookup & entry a_bank open & row equal.
REQ-015 miss_open, output, 1, lookup & entry open & row differs (precharge needed).
REQ-016 miss_closed, output, 1, lookup & entry closed (activate needed).
REQ-017 close_req, output, 1, at least one open entry has expired.
REQ-018 close_bank, output, log2(NBANKS), lowest-index expired bank; 0 when close_req low.
REQ-019 open_mask, output, NBANKS, per-bank open flags.

Function
REQ-020 match/miss_open/miss_closed SHALL be combinational from current inputs and registered state (zero latency) and SHALL be one-hot when lookup=1, all 0 when lookup=0.
REQ-021 Each entry SHALL hold row register, open flag, saturating idle counter.
REQ-022 Per-entry update priority, highest first: newrow to this bank; close_ack for this bank (close_bank==this, close_req=1); precharge to this bank; precharge_all; hold.
REQ-023 newrow SHALL load row, set open, clear idle counter; newrow and any close event on the same bank in the same cycle -> bank open with new row.
REQ-024 precharge_all together with newrow SHALL close every bank except a_bank, which opens with a_row.
REQ-025 Idle counter of an open entry SHALL clear on a cycle with lookup & match for that bank, otherwise increment, saturating at IDLE_CYCLES; closed entries hold counter at 0.
REQ-026 Entry SHALL be expired when open and counter == IDLE_CYCLES (IDLE_CYCLES=0: never expired).
REQ-027 close_req/close_bank SHALL be combinational from expired flags, lowest index wins; close_ack while close_req=0 SHALL be ignored.
REQ-028 New match on an expired bank SHALL clear its counter and withdraw its request next cycle.
REQ-029 open_mask SHALL reflect registered open flags.

Reset
REQ-030 On resl=0, asynchronously: all rows 0, all open flags 0, all counters 0; outputs match=0, miss_open=0, miss_closed=lookup, close_req=0, close_bank=0, open_mask=0.
REQ-031 Reset asserted mid-operation SHALL discard all state; first edge after deassertion SHALL behave as from reset.

Structure
REQ-032 Shared package SHALL hold default NBANKS, ROW_W, IDLE_W, IDLE_CYCLES and the bank-index width function.
REQ-033 SHALL instantiate sub-module bank_entry (row, open flag, idle counter, expired flag) NBANKS times via generate; priority encoder and output mux in bank_tracker.

Verification (NBANKS=4, ROW_W=11, IDLE_CYCLES=8)
REQ-034 Reset, lookup bank 2 row 0x123 -> miss_closed=1; newrow bank 2 row 0x123, next cycle lookup -> match=1, open_mask=4'b0100.
REQ-035 Bank 2 open row 0x123, lookup row 0x124 -> miss_open=1; precharge bank 2 -> next lookup miss_closed=1.
REQ-036 Banks 1 and 3 open, no access 8 cycles -> close_req=1, close_bank=1; close_ack -> close_bank=3 next cycle; second close_ack -> close_req=0, open_mask=0.
REQ-037 Bank 1 open, idle 7 cycles then match on bank 1 -> counter cleared, close_req stays 0 for further 7 cycles.
REQ-038 Same cycle newrow bank 0 row 0x7FF and precharge_all with banks 0-3 open -> open_mask=4'b0001, lookup bank 0 row 0x7FF match=1.
REQ-039 resl pulsed low mid-activity (all banks open) -> open_mask=0, close_req=0 immediately, without clock edge.
